// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: register selects,
// SPICON/SPSTR bit positions, transfer FSM states and the SCLK rate helper.
package spi_pkg;

    localparam logic [1:0] SEL_SPDAT  = 2'd0;
    localparam logic [1:0] SEL_SPICON = 2'd1;
    localparam logic [1:0] SEL_SPSTR  = 2'd2;

    localparam int CON_SPIE = 7;
    localparam int CON_SPEN = 6;
    localparam int CON_CPOL = 3;
    localparam int CON_CPHA = 2;

    localparam int STR_SPIF = 7;
    localparam int STR_WCOL = 6;
    localparam int STR_BUSY = 4;

    // A byte transfer is always 16 SCLK edges (8 leading, 8 trailing).
    localparam int XFER_EDGES = 16;
    localparam int EDGE_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } xfer_state_e;

    function automatic int half_cycles(input int spr);
        return 1 << spr;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: toggles SCLK every H = 2^SPR system clocks for 16 edges after
// start, idling at CPOL otherwise, and flags the clock edge on which each SCLK edge lands.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int SPR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [SPR_W-1:0]  spr_i,
    input  logic              cpol_i,
    output logic              sclk_o,
    output logic              lead_edge_o,
    output logic              trail_edge_o,
    output logic [EDGE_W-1:0] edge_cnt_o
);

    localparam int CNT_W = 1 << SPR_W;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  reload_q;
    logic [EDGE_W-1:0] edge_q;
    logic              run_q;
    logic              sclk_q;
    logic              cpol_q;
    logic              fire;
    logic [CNT_W-1:0]  start_reload;

    assign start_reload = CNT_W'(half_cycles(int'(spr_i)) - 1);

    // The pulses mark the cycle whose closing clock edge moves SCLK, so the
    // controller shifts/samples on exactly the same edge SCLK changes.
    assign fire         = run_q && (cnt_q == '0);
    assign lead_edge_o  = fire && !edge_q[0];
    assign trail_edge_o = fire &&  edge_q[0];
    assign edge_cnt_o   = edge_q;
    assign sclk_o       = sclk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            reload_q <= '0;
            edge_q   <= '0;
            run_q    <= 1'b0;
            sclk_q   <= 1'b0;
            cpol_q   <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= start_reload;
            reload_q <= start_reload;
            edge_q   <= '0;
            run_q    <= 1'b1;
            sclk_q   <= cpol_i;
            cpol_q   <= cpol_i;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                cnt_q  <= reload_q;
                edge_q <= edge_q + 1'b1;
                if (edge_q == EDGE_W'(XFER_EDGES - 1)) begin
                    run_q  <= 1'b0;
                    sclk_q <= cpol_q;
                end else begin
                    sclk_q <= ~sclk_q;
                end
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else begin
            sclk_q <= cpol_i;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI transfer controller: SPDAT/SPICON/SPSTR register file on the
// RSEL bus, byte shifter and transfer FSM driving the SCLK generator.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int SPR_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] DO,
    input  logic [1:0]        RSEL,
    input  logic              WR,
    input  logic              RD,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic              IRQ
);

    xfer_state_e       state_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              mosi_q;
    logic              cpha_q;

    logic [DATA_W-1:0] spdat_q,  spdat_d;
    logic [DATA_W-1:0] spicon_q, spicon_d;
    logic [DATA_W-1:0] do_q,     do_d;
    logic              spif_q,   spif_d;
    logic              wcol_q,   wcol_d;

    logic              busy;
    logic              wr_spdat, wr_spicon, wr_spstr, rd_spdat;
    logic              start;
    logic              lead_edge, trail_edge;
    logic [EDGE_W-1:0] edge_cnt;
    logic              last_edge, shift_edge, sample_edge;
    logic [DATA_W-1:0] spstr_val;
    logic [DATA_W-1:0] rd_data;

    assign busy      = (state_q != IDLE);
    assign wr_spdat  = WR && (RSEL == SEL_SPDAT);
    assign wr_spicon = WR && (RSEL == SEL_SPICON);
    assign wr_spstr  = WR && (RSEL == SEL_SPSTR);
    assign rd_spdat  = RD && (RSEL == SEL_SPDAT);
    assign start     = wr_spdat && (state_q == IDLE) && spicon_q[CON_SPEN];

    spi_clk_gen #(
        .SPR_W (SPR_W)
    ) u_clk_gen (
        .clk_i        (CLK),
        .rst_i        (RST),
        .start_i      (start),
        .spr_i        (spicon_q[SPR_W-1:0]),
        .cpol_i       (spicon_q[CON_CPOL]),
        .sclk_o       (SCLK),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .edge_cnt_o   (edge_cnt)
    );

    // In CPHA=0 the first bit is already on MOSI before edge 1, so the final
    // trailing edge has nothing left to shift and MOSI keeps bit 0.
    assign last_edge   = (lead_edge || trail_edge) && (edge_cnt == EDGE_W'(XFER_EDGES - 1));
    assign shift_edge  = cpha_q ? lead_edge : (trail_edge && !last_edge);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            mosi_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        cpha_q  <= spicon_q[CON_CPHA];
                        rx_q    <= '0;
                        if (spicon_q[CON_CPHA]) begin
                            tx_q <= DI;
                        end else begin
                            tx_q   <= {DI[DATA_W-2:0], 1'b0};
                            mosi_q <= DI[DATA_W-1];
                        end
                    end
                end
                SHIFT: begin
                    if (shift_edge) begin
                        mosi_q <= tx_q[DATA_W-1];
                        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (sample_edge) begin
                        rx_q <= {rx_q[DATA_W-2:0], MISO};
                    end
                    if (last_edge) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        spstr_val           = '0;
        spstr_val[STR_SPIF] = spif_q;
        spstr_val[STR_WCOL] = wcol_q;
        spstr_val[STR_BUSY] = busy;
        case (RSEL)
            SEL_SPDAT:  rd_data = spdat_q;
            SEL_SPICON: rd_data = spicon_q;
            SEL_SPSTR:  rd_data = spstr_val;
            default:    rd_data = '0;
        endcase
    end

    // Completion and collision are ordered after CPU clears so that a status
    // event landing on the same edge as a clear is never lost.
    always_comb begin
        spicon_d = spicon_q;
        spdat_d  = spdat_q;
        spif_d   = spif_q;
        wcol_d   = wcol_q;
        do_d     = do_q;

        if (wr_spicon) begin
            spicon_d = DI;
        end
        if (wr_spdat && !busy) begin
            spdat_d = DI;
        end
        if (wr_spdat || rd_spdat) begin
            spif_d = 1'b0;
        end
        if (wr_spstr && DI[STR_WCOL]) begin
            wcol_d = 1'b0;
        end
        if (wr_spdat && busy) begin
            wcol_d = 1'b1;
        end
        if (state_q == DONE) begin
            spdat_d = rx_q;
            spif_d  = 1'b1;
        end
        if (RD) begin
            do_d = rd_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            spicon_q <= '0;
            spdat_q  <= '0;
            spif_q   <= 1'b0;
            wcol_q   <= 1'b0;
            do_q     <= '0;
        end else begin
            spicon_q <= spicon_d;
            spdat_q  <= spdat_d;
            spif_q   <= spif_d;
            wcol_q   <= wcol_d;
            do_q     <= do_d;
        end
    end

    assign DO   = do_q;
    assign MOSI = mosi_q;
    assign IRQ  = spif_q && spicon_q[CON_SPIE];

endmodule
